cache_axi_arbiter: RTL

- Shares one AXI3 master port between the I-cache refill path and the D-cache refill and writeback paths.
- Sits between the two caches and the SoC AXI interconnect. The caches' busy signals to pipeline hazard control stay asserted until this block returns the line or completes the write.
- Allows one outstanding read burst and one outstanding write burst at a time.
- Holds a D-cache read to a line address until any in-flight writeback of that line has received its B response.

---
 rtl/cache_axi_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/cache_axi_arbiter.sv
// Shares one AXI3 master between the I-cache refill, D-cache refill and D-cache writeback paths.
// One read burst and one write burst may be outstanding; D$ reads wait on an in-flight writeback of the same line.
module cache_axi_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 4,
    parameter int LEN_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_rd_req,
    input  logic [ADDR_W-1:0] ic_rd_addr,
    input  logic [LEN_W-1:0]  ic_rd_len,
    output logic              ic_rd_gnt,
    output logic              ic_ret_valid,
    output logic              ic_ret_last,
    input  logic              dc_rd_req,
    input  logic [ADDR_W-1:0] dc_rd_addr,
    input  logic [LEN_W-1:0]  dc_rd_len,
    output logic              dc_rd_gnt,
    output logic              dc_ret_valid,
    output logic              dc_ret_last,
    output logic [DATA_W-1:0] ret_data,
    input  logic              dc_wr_req,
    input  logic [ADDR_W-1:0] dc_wr_addr,
    input  logic [LEN_W-1:0]  dc_wr_len,
    input  logic [DATA_W-1:0] dc_wr_data,
    output logic              dc_wr_next,
    output logic              dc_wr_done,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [LEN_W-1:0]  arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [LEN_W-1:0]  awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [3:0]        wid,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [3:0]        bid,
    input  logic              bvalid,
    output logic              bready
);
    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_t;

    rd_state_t         rd_state_reg, rd_state_next;
    wr_state_t         wr_state_reg, wr_state_next;
    logic [ADDR_W-1:0] araddr_reg, araddr_next, awaddr_reg, awaddr_next;
    logic [LEN_W-1:0]  arlen_reg, arlen_next, awlen_reg, awlen_next;
    logic [LEN_W-1:0]  beat_cnt_reg, beat_cnt_next;
    logic              arid_reg, arid_next;          // 0 = I$, 1 = D$
    logic              last_winner_reg, last_winner_next;  // 1 = D$ won the last contention
    logic              dc_line_hit, ic_elig, dc_elig, pick_dc;
    logic              unused_rsp;

    assign unused_rsp = ^{rid, bid};

    assign dc_line_hit = (wr_state_reg != W_IDLE) &&
                         (dc_rd_addr[ADDR_W-1:OFFSET_W] == awaddr_reg[ADDR_W-1:OFFSET_W]);
    assign ic_elig = ic_rd_req;
    assign dc_elig = dc_rd_req && !dc_line_hit;
    assign pick_dc = dc_elig && (!ic_elig || !last_winner_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_reg    <= R_IDLE;
            wr_state_reg    <= W_IDLE;
            araddr_reg      <= '0;
            arlen_reg       <= '0;
            arid_reg        <= 1'b0;
            last_winner_reg <= 1'b0;
            awaddr_reg      <= '0;
            awlen_reg       <= '0;
            beat_cnt_reg    <= '0;
        end else begin
            rd_state_reg    <= rd_state_next;
            wr_state_reg    <= wr_state_next;
            araddr_reg      <= araddr_next;
            arlen_reg       <= arlen_next;
            arid_reg        <= arid_next;
            last_winner_reg <= last_winner_next;
            awaddr_reg      <= awaddr_next;
            awlen_reg       <= awlen_next;
            beat_cnt_reg    <= beat_cnt_next;
        end
    end

    always_comb begin
        rd_state_next    = rd_state_reg;
        araddr_next      = araddr_reg;
        arlen_next       = arlen_reg;
        arid_next        = arid_reg;
        last_winner_next = last_winner_reg;
        ic_rd_gnt        = 1'b0;
        dc_rd_gnt        = 1'b0;
        arvalid          = 1'b0;
        rready           = 1'b0;
        ic_ret_valid     = 1'b0;
        ic_ret_last      = 1'b0;
        dc_ret_valid     = 1'b0;
        dc_ret_last      = 1'b0;
        case (rd_state_reg)
            R_IDLE: begin
                // Grant is gated by rst so no pulse escapes while the block is being cleared.
                if (!rst && (ic_elig || dc_elig)) begin
                    ic_rd_gnt     = !pick_dc;
                    dc_rd_gnt     = pick_dc;
                    araddr_next   = pick_dc ? dc_rd_addr : ic_rd_addr;
                    arlen_next    = pick_dc ? dc_rd_len : ic_rd_len;
                    arid_next     = pick_dc;
                    if (ic_elig && dc_elig) begin
                        last_winner_next = pick_dc;
                    end
                    rd_state_next = R_AR;
                end
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    rd_state_next = R_DATA;
                end
            end
            R_DATA: begin
                rready       = 1'b1;
                ic_ret_valid = rvalid && !arid_reg;
                ic_ret_last  = rvalid && rlast && !arid_reg;
                dc_ret_valid = rvalid && arid_reg;
                dc_ret_last  = rvalid && rlast && arid_reg;
                if (rvalid && rlast) begin
                    rd_state_next = R_IDLE;
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_next = wr_state_reg;
        awaddr_next   = awaddr_reg;
        awlen_next    = awlen_reg;
        beat_cnt_next = beat_cnt_reg;
        awvalid       = 1'b0;
        wvalid        = 1'b0;
        wlast         = 1'b0;
        bready        = 1'b0;
        dc_wr_next    = 1'b0;
        dc_wr_done    = 1'b0;
        case (wr_state_reg)
            W_IDLE: begin
                if (dc_wr_req) begin
                    awaddr_next   = dc_wr_addr;
                    awlen_next    = dc_wr_len;
                    beat_cnt_next = '0;
                    wr_state_next = W_AW;
                end
            end
            W_AW: begin
                awvalid = 1'b1;
                if (awready) begin
                    wr_state_next = W_DATA;
                end
            end
            W_DATA: begin
                wvalid = 1'b1;
                wlast  = (beat_cnt_reg == awlen_reg);
                if (wready) begin
                    dc_wr_next    = 1'b1;
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                    if (beat_cnt_reg == awlen_reg) begin
                        wr_state_next = W_RESP;
                    end
                end
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    dc_wr_done    = 1'b1;
                    wr_state_next = W_IDLE;
                end
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    assign ret_data = rdata;
    assign arid     = {3'b000, arid_reg};
    assign araddr   = araddr_reg;
    assign arlen    = arlen_reg;
    assign arsize   = 3'b010;
    assign arburst  = 2'b01;
    assign awid     = 4'd1;
    assign awaddr   = awaddr_reg;
    assign awlen    = awlen_reg;
    assign awsize   = 3'b010;
    assign awburst  = 2'b01;
    assign wid      = 4'd1;
    assign wdata    = dc_wr_data;
    assign wstrb    = 4'hF;
endmodule
